// File: rtl/cpu_defs.sv
// Shared definitions for the MIPS core pipeline registers: writeback-source
// codes, the EX->MEM payload layout and the reset PC.
package cpu_defs;

    localparam logic [3:0] REG_WE_NONE = 4'b0000;
    localparam logic [3:0] REG_WE_ALU  = 4'b0001;
    localparam logic [3:0] REG_WE_LO   = 4'b0010;
    localparam logic [3:0] REG_WE_HI   = 4'b0100;
    localparam logic [3:0] REG_WE_CP0  = 4'b1000;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    // pc sits in the most significant bits so a reset image is easy to build
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_r1;
        logic [63:0] hilo;
        logic [31:0] cp0_data;
        logic [3:0]  reg_we;
        logic [4:0]  rw;
    } ex_mem_core_t;

    localparam int EX_MEM_CORE_W = $bits(ex_mem_core_t);

    function automatic int ex_mem_payload_w(input int mem_ctrl_w);
        return EX_MEM_CORE_W + mem_ctrl_w;
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: a valid bit plus a payload register with load/clear/hold.
// A clear beats a load for the valid bit; the payload still follows load.
module pipe_entry #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    logic         valid_reg;
    logic [W-1:0] data_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_reg <= 1'b0;
            data_reg  <= RST_VAL;
        end else begin
            if (load)
                data_reg <= d;
            if (clear)
                valid_reg <= 1'b0;
            else if (load)
                valid_reg <= 1'b1;
        end
    end

    assign valid = valid_reg;
    assign q     = data_reg;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with valid/allowin handshake and forwarding gating.
// Define EX_MEM_SKID_EN to add a skid entry that registers ex_allowin.
module ex_mem_pipe
    import cpu_defs::*;
#(
    parameter int          MEM_CTRL_W = 8,
    parameter logic [31:0] RESET_PC   = cpu_defs::RESET_PC
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  ex_valid,
    output logic                  ex_allowin,
    input  logic                  mem_allowin,
    output logic                  mem_valid,
    input  logic [31:0]           pc_ex,
    output logic [31:0]           pc_mem,
    input  logic [31:0]           alu_r1_ex,
    output logic [31:0]           alu_r1_mem,
    input  logic [63:0]           hilo_ex,
    output logic [63:0]           hilo_mem,
    input  logic [31:0]           cp0_data_ex,
    output logic [31:0]           cp0_data_mem,
    input  logic [3:0]            reg_we_direct_ex,
    output logic [3:0]            reg_we_direct_mem,
    input  logic [4:0]            rw_ex,
    output logic [4:0]            rw_mem,
    input  logic [MEM_CTRL_W-1:0] mem_ctrl_ex,
    output logic [MEM_CTRL_W-1:0] mem_ctrl_mem
);

    localparam int PW = ex_mem_payload_w(MEM_CTRL_W);
    localparam logic [PW-1:0] PAYLOAD_RST =
        {{MEM_CTRL_W{1'b0}}, RESET_PC, {(EX_MEM_CORE_W-32){1'b0}}};

    ex_mem_core_t  core_ex, core_q;
    logic [PW-1:0] payload_ex, main_d, main_q;
    logic          main_v, main_load, main_clear, ex_fire;

    assign core_ex    = {pc_ex, alu_r1_ex, hilo_ex, cp0_data_ex, reg_we_direct_ex, rw_ex};
    assign payload_ex = {mem_ctrl_ex, core_ex};
    assign ex_fire    = ex_valid & ex_allowin;

`ifdef EX_MEM_SKID_EN
    logic          sk_v, skid_load, skid_clear;
    logic [PW-1:0] sk_q;

    // allowin depends only on registered skid occupancy, never on mem_allowin
    assign ex_allowin = !sk_v | flush;
    assign main_d     = sk_v ? sk_q : payload_ex;
    assign main_load  = (sk_v & mem_allowin) | (ex_fire & (!main_v | mem_allowin));
    assign main_clear = flush | (mem_allowin & !main_load);
    assign skid_load  = ex_fire & main_v & !mem_allowin;
    assign skid_clear = flush | (sk_v & mem_allowin);

    pipe_entry #(.W(PW), .RST_VAL(PAYLOAD_RST)) u_skid (
        .clk    (clk),
        .resetn (resetn),
        .load   (skid_load),
        .clear  (skid_clear),
        .d      (payload_ex),
        .valid  (sk_v),
        .q      (sk_q)
    );
`else
    assign ex_allowin = flush | !main_v | mem_allowin;
    assign main_d     = payload_ex;
    assign main_load  = ex_fire;
    assign main_clear = flush | (mem_allowin & !ex_fire);
`endif

    pipe_entry #(.W(PW), .RST_VAL(PAYLOAD_RST)) u_main (
        .clk    (clk),
        .resetn (resetn),
        .load   (main_load),
        .clear  (main_clear),
        .d      (main_d),
        .valid  (main_v),
        .q      (main_q)
    );

    assign {mem_ctrl_mem, core_q} = main_q;
    assign mem_valid    = main_v;
    assign pc_mem       = core_q.pc;
    assign alu_r1_mem   = core_q.alu_r1;
    assign hilo_mem     = core_q.hilo;
    assign cp0_data_mem = core_q.cp0_data;

    // bubbles must never match an ID-stage forwarding compare
    assign reg_we_direct_mem = main_v ? core_q.reg_we : REG_WE_NONE;
    assign rw_mem            = main_v ? core_q.rw : 5'd0;

    // non-one-hot writeback sources pass through; flagged in simulation only
    always_comb begin
        if (ex_fire)
            assert ($onehot0(reg_we_direct_ex));
    end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Scoreboard bench for ex_mem_pipe: a FIFO model of accepted entries is checked
// against the MEM-side outputs every cycle (works with or without EX_MEM_SKID_EN).
module tb_ex_mem_pipe;
    import cpu_defs::*;

`ifdef EX_MEM_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        resetn, flush, ex_valid, mem_allowin;
    logic        ex_allowin, mem_valid;
    logic [31:0] pc_ex, pc_mem, alu_r1_ex, alu_r1_mem, cp0_data_ex, cp0_data_mem;
    logic [63:0] hilo_ex, hilo_mem;
    logic [3:0]  reg_we_direct_ex, reg_we_direct_mem;
    logic [4:0]  rw_ex, rw_mem;
    logic [7:0]  mem_ctrl_ex, mem_ctrl_mem;

    ex_mem_pipe #(.MEM_CTRL_W(8)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .ex_valid(ex_valid), .ex_allowin(ex_allowin),
        .mem_allowin(mem_allowin), .mem_valid(mem_valid),
        .pc_ex(pc_ex), .pc_mem(pc_mem),
        .alu_r1_ex(alu_r1_ex), .alu_r1_mem(alu_r1_mem),
        .hilo_ex(hilo_ex), .hilo_mem(hilo_mem),
        .cp0_data_ex(cp0_data_ex), .cp0_data_mem(cp0_data_mem),
        .reg_we_direct_ex(reg_we_direct_ex), .reg_we_direct_mem(reg_we_direct_mem),
        .rw_ex(rw_ex), .rw_mem(rw_mem),
        .mem_ctrl_ex(mem_ctrl_ex), .mem_ctrl_mem(mem_ctrl_mem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [63:0] hilo;
        logic [31:0] cp0;
        logic [3:0]  we;
        logic [4:0]  rw;
        logic [7:0]  mc;
    } item_t;

    item_t       sb[$];
    int          total = 0;
    int          bad = 0;
    bit          mon_en = 0;
    bit          acc_now = 0;
    bit          exp_allow = 1;
    bit          drain_flag = 0;
    logic [31:0] last_alu;
    int          occ;
    logic [3:0]  we_tab[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // one cycle of stimulus; the accepted entry (if any) goes to the scoreboard
    task automatic step(input bit ev, input bit ma, input bit fl,
                        input logic [4:0] rw, input logic [3:0] we, input logic [63:0] hilo);
        item_t it;
        @(posedge clk);
        #1;
        rw_ex = rw;
        reg_we_direct_ex = we;
        hilo_ex = hilo;
        pc_ex = $urandom;
        alu_r1_ex = $urandom;
        cp0_data_ex = $urandom;
        mem_ctrl_ex = 8'($urandom);
        mem_allowin = ma;
        flush = fl;
        ex_valid = ev;
        exp_allow = fl || (CAP == 1 ? (sb.size() == 0 || ma) : (sb.size() < CAP));
        acc_now = ev && exp_allow && !fl;
        if (acc_now) begin
            it = '{pc: pc_ex, alu: alu_r1_ex, hilo: hilo, cp0: cp0_data_ex,
                   we: we, rw: rw, mc: mem_ctrl_ex};
            sb.push_back(it);
        end
    endtask

    // monitor: compares the presented entry against the oldest expected one
    always @(negedge clk) begin
        if (mon_en) begin
            occ = sb.size() - int'(acc_now);
            chk("ex_allowin", {63'd0, ex_allowin}, {63'd0, exp_allow});
            chk("mem_valid", {63'd0, mem_valid}, {63'd0, occ > 0});
            if (drain_flag)
                chk("drain_hold_alu", {32'd0, alu_r1_mem}, {32'd0, last_alu});
            drain_flag = 0;
            if (occ > 0) begin
                chk("pc_mem", {32'd0, pc_mem}, {32'd0, sb[0].pc});
                chk("alu_r1_mem", {32'd0, alu_r1_mem}, {32'd0, sb[0].alu});
                chk("hilo_mem", hilo_mem, sb[0].hilo);
                chk("cp0_data_mem", {32'd0, cp0_data_mem}, {32'd0, sb[0].cp0});
                chk("reg_we_mem", {60'd0, reg_we_direct_mem}, {60'd0, sb[0].we});
                chk("rw_mem", {59'd0, rw_mem}, {59'd0, sb[0].rw});
                chk("mem_ctrl_mem", {56'd0, mem_ctrl_mem}, {56'd0, sb[0].mc});
            end else begin
                chk("rw_gate", {59'd0, rw_mem}, 64'd0);
                chk("we_gate", {60'd0, reg_we_direct_mem}, 64'd0);
            end
            if (flush) begin
                sb.delete();
            end else if (occ > 0 && mem_allowin) begin
                last_alu = sb[0].alu;
                drain_flag = (occ == 1) && !acc_now;
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        we_tab[0] = REG_WE_NONE;
        we_tab[1] = REG_WE_ALU;
        we_tab[2] = REG_WE_LO;
        we_tab[3] = REG_WE_HI;
        we_tab[4] = REG_WE_CP0;
        resetn = 1'b0;
        flush = 1'b0;
        ex_valid = 1'b0;
        mem_allowin = 1'b0;
        pc_ex = '0; alu_r1_ex = '0; hilo_ex = '0; cp0_data_ex = '0;
        reg_we_direct_ex = '0; rw_ex = '0; mem_ctrl_ex = '0;
        #23 resetn = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
        chk("rst_we", {60'd0, reg_we_direct_mem}, 64'd0);
        chk("rst_rw", {59'd0, rw_mem}, 64'd0);
        chk("rst_pc", {32'd0, pc_mem}, 64'h0000_0000_BFC0_0000);
        chk("rst_hilo", hilo_mem, 64'd0);
        chk("rst_ex_allowin", {63'd0, ex_allowin}, 64'd1);
        mon_en = 1;

        // back-to-back loads then drain without refill
        step(1, 1, 0, 5'd8, REG_WE_ALU, 64'd0);
        step(1, 1, 0, 5'd9, REG_WE_ALU, 64'd0);
        step(1, 1, 0, 5'd10, REG_WE_ALU, 64'd0);
        step(0, 1, 0, 5'd0, REG_WE_NONE, 64'd0);
        step(0, 1, 0, 5'd0, REG_WE_NONE, 64'd0);

        // load HI result and stall MEM for three cycles
        step(1, 1, 0, 5'd3, REG_WE_HI, 64'h1111_2222_3333_4444);
        step(0, 0, 0, 5'd0, REG_WE_NONE, 64'd0);
        step(0, 0, 0, 5'd0, REG_WE_NONE, 64'd0);
        step(0, 0, 0, 5'd0, REG_WE_NONE, 64'd0);
        chk("stall_hi_word", {32'd0, hilo_mem[63:32]}, 64'h0000_0000_1111_2222);
        step(0, 1, 0, 5'd0, REG_WE_NONE, 64'd0);

        // flush together with a load
        step(1, 1, 1, 5'd5, REG_WE_ALU, 64'd0);
        step(0, 1, 0, 5'd0, REG_WE_NONE, 64'd0);
        step(0, 1, 0, 5'd0, REG_WE_NONE, 64'd0);

`ifdef EX_MEM_SKID_EN
        // fill main and skid under stall, then release in order
        step(1, 0, 0, 5'd20, REG_WE_ALU, 64'hA);
        step(1, 0, 0, 5'd21, REG_WE_LO, 64'hB);
        step(1, 0, 0, 5'd22, REG_WE_CP0, 64'hC);
        step(0, 1, 0, 5'd0, REG_WE_NONE, 64'd0);
        step(0, 1, 0, 5'd0, REG_WE_NONE, 64'd0);
        step(0, 1, 0, 5'd0, REG_WE_NONE, 64'd0);
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 15) == 0,
                 5'($urandom),
                 we_tab[$urandom_range(0, 4)],
                 {$urandom, $urandom});
        end

        // reset in the middle of a stall
        step(1, 1, 0, 5'd17, REG_WE_ALU, 64'd0);
        step(0, 0, 0, 5'd0, REG_WE_NONE, 64'd0);
        #2;
        mon_en = 0;
        resetn = 1'b0;
        #1;
        chk("midrst_mem_valid", {63'd0, mem_valid}, 64'd0);
        chk("midrst_rw", {59'd0, rw_mem}, 64'd0);
        chk("midrst_pc", {32'd0, pc_mem}, 64'h0000_0000_BFC0_0000);
        sb.delete();
        acc_now = 0;
        drain_flag = 0;
        ex_valid = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        step(0, 1, 0, 5'd0, REG_WE_NONE, 64'd0);
        mon_en = 1;
        step(0, 1, 0, 5'd0, REG_WE_NONE, 64'd0);
        step(0, 1, 0, 5'd0, REG_WE_NONE, 64'd0);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
